// File: rtl/data_gen_pkg.sv
// Shared definitions for the counting-pattern stream source.
//   state_e : run-control FSM states (idle, streaming, completion pulse)
//   StateW  : width of the state encoding
package data_gen_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/data_gen_axis.sv
// Counting-pattern AXI4-Stream source under ap_ctrl_hs-style start/done control.
// Each accepted start emits `size` beats carrying 0,1,2,...; the final beat has tlast.
// Ports:
//   ap_clk, ap_rst        : clock, synchronous active-high reset
//   size                  : beats per run, captured when a start is accepted
//   ap_start              : run request (single-cycle pulse suffices)
//   ap_done/idle/ready    : completion pulse, idle level, start-accepted pulse
//   tdata/tvalid/tlast    : stream master outputs (registered)
//   tready                : downstream accept
module data_gen_axis
    import data_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [31:0]      size,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [WIDTH-1:0] tdata,
    output logic             tvalid,
    output logic             tlast,
    input  logic             tready
);

    state_e           state_q, state_d;
    logic [31:0]      idx_q, idx_d;
    logic [31:0]      size_q, size_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic [31:0]      idx_nxt;

    assign idx_nxt = idx_q + 32'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        size_d   = size_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    size_d  = size;
                    idx_d   = '0;
                    tdata_d = '0;
                    if (size == 32'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StRun;
                        tvalid_d = 1'b1;
                        tlast_d  = (size == 32'd1);
                    end
                end
            end
            StRun: begin
                // tvalid is always high in StRun, so tready alone marks a handshake.
                if (tready) begin
                    if (tlast_q) begin
                        state_d  = StDone;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        idx_d   = idx_nxt;
                        // Cast truncates or zero-extends the 32-bit index to WIDTH.
                        tdata_d = WIDTH'(idx_nxt);
                        tlast_d = (idx_nxt == size_q - 32'd1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            size_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            size_q   <= size_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign ap_idle  = (state_q == StIdle);
    assign ap_done  = (state_q == StDone);
    assign ap_ready = ap_idle & ap_start;
    assign tdata    = tdata_q;
    assign tvalid   = tvalid_q;
    assign tlast    = tlast_q;

endmodule

// File: tb/tb_data_gen_axis.sv
// Scoreboard bench for data_gen_axis: stimulus pushes expected beats per run,
// a negedge monitor pops and compares on every handshake.
module tb_data_gen_axis;

    localparam int unsigned W = 32;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic [31:0]  size = '0;
    logic         ap_start = 1'b0;
    logic         ap_done, ap_idle, ap_ready;
    logic [W-1:0] tdata;
    logic         tvalid, tlast;
    logic         tready = 1'b0;

    data_gen_axis #(.WIDTH(W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .size     (size),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .tdata    (tdata),
        .tvalid   (tvalid),
        .tlast    (tlast),
        .tready   (tready)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_done_cyc  = -1;
    int    exp_first_cyc = -1;
    int    done_seen     = 0;
    int    done_exp      = 0;
    int    tready_mode   = 0;  // 0: always high, 1: toggle, 2: random

    // tready driver
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (tready_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        beat_t       b;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (tvalid && prev_stall) begin
                check("stall_data", tdata, prev_data);
                check("stall_last", tlast, prev_last);
            end
            if (cyc == exp_first_cyc) begin
                check("first_valid", tvalid, 1);
                check("first_data", tdata, 0);
            end
            if (cyc == exp_done_cyc) check("done_pulse", ap_done, 1);
            else if (ap_done)        check("done_unexpected_cycle", cyc, exp_done_cyc);
            if (ap_done) done_seen++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got tdata %0h, expected no beat (cycle %0d)",
                             tdata, cyc);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", tdata, b.data);
                    check("beat_last", tlast, b.last);
                end
                if (tlast) exp_done_cyc = cyc + 1;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Issue one run of n beats; optionally poke ap_start while busy.
    task automatic start_run(input int n, input bit poke);
        int t;
        t = 0;
        while (!ap_idle && t < 200) begin
            @(posedge ap_clk);
            #1;
            t++;
        end
        check("idle_before_start", ap_idle, 1);
        size     = 32'(n);
        ap_start = 1'b1;
        #1;
        check("ready_on_start", ap_ready, 1);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: 32'(i), last: (i == n - 1)});
        if (n == 0) exp_done_cyc = cyc + 1;
        else        exp_first_cyc = cyc + 1;
        done_exp++;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        size     = $urandom;  // must not affect the run in progress
        check("ready_pulse_width", ap_ready, 0);
        check("busy_after_start", ap_idle, 0);
        if (poke && n >= 3) begin
            @(posedge ap_clk);
            #1;
            ap_start = 1'b1;
            size     = 32'd7;
            #1;
            check("ready_ignored_busy", ap_ready, 0);
            @(posedge ap_clk);
            #1;
            ap_start = 1'b0;
        end
        t = 0;
        while (!ap_done && t < 2000) begin
            @(posedge ap_clk);
            #1;
            t++;
        end
        check("done_within_budget", ap_done, 1);
        @(posedge ap_clk);
        #1;
        check("done_one_cycle", ap_done, 0);
        check("idle_after_done", ap_idle, 1);
    endtask

    initial begin
        // Reset
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_idle", ap_idle, 1);
        check("rst_tvalid", tvalid, 0);
        check("rst_done", ap_done, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_ready", ap_ready, 0);
        @(posedge ap_clk);
        #1;

        tready_mode = 0;
        start_run(4, 1'b0);
        tready_mode = 1;
        start_run(5, 1'b0);
        tready_mode = 0;
        repeat (3) start_run(3, 1'b0);  // back-to-back
        start_run(0, 1'b0);
        start_run(6, 1'b1);

        // Mid-run reset: size 8, abort after beat 2 is taken
        tready_mode = 0;
        size     = 32'd8;
        ap_start = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back('{data: 32'(i), last: (i == 7)});
        exp_first_cyc = cyc + 1;
        repeat (4) begin
            @(posedge ap_clk);
            #1;
            ap_start = 1'b0;
        end
        check("beats_before_reset", exp_q.size(), 5);
        ap_rst = 1'b1;
        exp_q.delete();
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("abort_tvalid", tvalid, 0);
        check("abort_idle", ap_idle, 1);
        check("abort_done", ap_done, 0);
        repeat (5) @(posedge ap_clk);
        #1;

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            tready_mode = 2;
            repeat ($urandom_range(0, 3)) begin
                @(posedge ap_clk);
                #1;
            end
            start_run(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)));
        end

        tready_mode = 0;
        repeat (4) @(posedge ap_clk);
        #1;
        check("done_count", done_seen, done_exp);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
